// File: rtl/stencil_cell_engine.sv
// Stencil cell engine: per-cell neighbour update in one of four modes, with per-sweep max-change and convergence tracking.
// Latency: 2 cycles from input handshake to out_* when unstalled; throughput 1 cell/cycle.
// Backpressure: a global enable freezes both stages while out_valid && !out_ready; in_ready mirrors that enable.
module stencil_cell_engine #(
  parameter int WIDTH = 8,
  parameter int CELLS = 16,
  parameter int CNT_W = $clog2(CELLS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_n,
  input  logic [WIDTH-1:0] in_s,
  input  logic [WIDTH-1:0] in_e,
  input  logic [WIDTH-1:0] in_w,
  input  logic [WIDTH-1:0] in_c,
  input  logic             in_fixed,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_val,
  output logic [WIDTH-1:0] out_delta,
  input  logic [WIDTH-1:0] threshold,
  input  logic             sweep_clear,
  output logic [CNT_W-1:0] cell_idx,
  output logic [WIDTH-1:0] max_delta,
  output logic             converged,
  output logic             sweep_done
);

  localparam int SUM_W = WIDTH + 2;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CELLS - 1);

  // Stage 1 registers: neighbour sum plus the centre and control fields.
  logic             s1_vld_q,   s1_vld_d;
  logic [SUM_W-1:0] s1_sum_q,   s1_sum_d;
  logic [WIDTH-1:0] s1_c_q,     s1_c_d;
  logic             s1_fixed_q, s1_fixed_d;
  logic [1:0]       s1_mode_q,  s1_mode_d;

  // Stage 2 (output) registers.
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_val_q,   out_val_d;
  logic [WIDTH-1:0] out_delta_q, out_delta_d;

  // Sweep tracking registers.
  logic [CNT_W-1:0] cell_idx_q,   cell_idx_d;
  logic [WIDTH-1:0] run_max_q,    run_max_d;
  logic [WIDTH-1:0] max_delta_q,  max_delta_d;
  logic             converged_q,  converged_d;
  logic             sweep_done_q, sweep_done_d;

  logic             en;
  logic             out_hs;
  logic [WIDTH-1:0] avg_trunc;
  logic [WIDTH-1:0] avg_round;
  logic [WIDTH-1:0] damped;
  logic [WIDTH-1:0] new_val;
  logic [WIDTH-1:0] sweep_max;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;
  assign out_hs   = out_valid_q && out_ready;

  assign out_valid  = out_valid_q;
  assign out_val    = out_val_q;
  assign out_delta  = out_delta_q;
  assign cell_idx   = cell_idx_q;
  assign max_delta  = max_delta_q;
  assign converged  = converged_q;
  assign sweep_done = sweep_done_q;

  // Stage 1: capture the neighbour sum and cell controls whenever the pipe advances (bubbles included).
  always_comb begin
    s1_vld_d   = s1_vld_q;
    s1_sum_d   = s1_sum_q;
    s1_c_d     = s1_c_q;
    s1_fixed_d = s1_fixed_q;
    s1_mode_d  = s1_mode_q;
    if (en) begin
      s1_vld_d   = in_valid;
      s1_sum_d   = {2'b00, in_n} + {2'b00, in_s} + {2'b00, in_e} + {2'b00, in_w};
      s1_c_d     = in_c;
      s1_fixed_d = in_fixed;
      s1_mode_d  = in_mode;
    end
  end

  // Stage 2: select the new value by mode (fixed cells pinned to centre) and form |new - old|.
  always_comb begin
    avg_trunc = WIDTH'(s1_sum_q >> 2);
    avg_round = WIDTH'((s1_sum_q + SUM_W'(2)) >> 2);
    damped    = WIDTH'(({1'b0, s1_c_q} + {1'b0, avg_trunc}) >> 1);
    new_val   = s1_c_q;
    if (!s1_fixed_q) begin
      case (s1_mode_q)
        2'd0:    new_val = avg_trunc;
        2'd1:    new_val = avg_round;
        2'd2:    new_val = damped;
        default: new_val = s1_c_q;
      endcase
    end
    out_valid_d = out_valid_q;
    out_val_d   = out_val_q;
    out_delta_d = out_delta_q;
    if (en) begin
      out_valid_d = s1_vld_q;
      out_val_d   = new_val;
      out_delta_d = (new_val >= s1_c_q) ? (new_val - s1_c_q) : (s1_c_q - new_val);
    end
  end

  // Sweep tracking: advance on output handshakes; a clear overrides a coincident sweep completion.
  always_comb begin
    cell_idx_d   = cell_idx_q;
    run_max_d    = run_max_q;
    max_delta_d  = max_delta_q;
    converged_d  = converged_q;
    sweep_done_d = 1'b0;
    sweep_max    = (out_delta_q > run_max_q) ? out_delta_q : run_max_q;
    if (sweep_clear) begin
      cell_idx_d = '0;
      run_max_d  = '0;
    end else if (out_hs) begin
      if (cell_idx_q == LAST_IDX) begin
        cell_idx_d   = '0;
        run_max_d    = '0;
        max_delta_d  = sweep_max;
        converged_d  = (sweep_max <= threshold);
        sweep_done_d = 1'b1;
      end else begin
        cell_idx_d = cell_idx_q + CNT_W'(1);
        run_max_d  = sweep_max;
      end
    end
  end

  // State register: all pipeline and sweep state cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q     <= 1'b0;
      s1_sum_q     <= '0;
      s1_c_q       <= '0;
      s1_fixed_q   <= 1'b0;
      s1_mode_q    <= 2'd0;
      out_valid_q  <= 1'b0;
      out_val_q    <= '0;
      out_delta_q  <= '0;
      cell_idx_q   <= '0;
      run_max_q    <= '0;
      max_delta_q  <= '0;
      converged_q  <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      s1_vld_q     <= s1_vld_d;
      s1_sum_q     <= s1_sum_d;
      s1_c_q       <= s1_c_d;
      s1_fixed_q   <= s1_fixed_d;
      s1_mode_q    <= s1_mode_d;
      out_valid_q  <= out_valid_d;
      out_val_q    <= out_val_d;
      out_delta_q  <= out_delta_d;
      cell_idx_q   <= cell_idx_d;
      run_max_q    <= run_max_d;
      max_delta_q  <= max_delta_d;
      converged_q  <= converged_d;
      sweep_done_q <= sweep_done_d;
    end
  end

endmodule

// File: tb/tb_stencil_cell_engine.sv
// Scoreboard bench for stencil_cell_engine (WIDTH=8, CELLS=4).
// Driver pushes reference results on each accepted cell; a negedge monitor pops and compares.
// Sweep bookkeeping is modelled as a list of per-cell deltas reduced at sweep end.
module tb_stencil_cell_engine;

  localparam int WIDTH = 8;
  localparam int CELLS = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_n, in_s, in_e, in_w, in_c;
  logic             in_fixed;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_val;
  logic [WIDTH-1:0] out_delta;
  logic [WIDTH-1:0] threshold;
  logic             sweep_clear;
  logic [1:0]       cell_idx;
  logic [WIDTH-1:0] max_delta;
  logic             converged;
  logic             sweep_done;

  stencil_cell_engine #(.WIDTH(WIDTH), .CELLS(CELLS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_n(in_n), .in_s(in_s), .in_e(in_e), .in_w(in_w), .in_c(in_c),
    .in_fixed(in_fixed), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_val(out_val), .out_delta(out_delta),
    .threshold(threshold), .sweep_clear(sweep_clear),
    .cell_idx(cell_idx), .max_delta(max_delta),
    .converged(converged), .sweep_done(sweep_done)
  );

  typedef struct {
    int val;
    int dlt;
    int acc;
    bit lat;
  } exp_t;

  exp_t q[$];
  int   sw_q[$];
  int   exp_max;
  bit   exp_conv;
  bit   exp_done;
  int   cyc;
  int   n_checks;
  int   n_pass;
  bit   rnd_rdy;
  int   bp_k;
  bit   saw_stall;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Behavioural reference: stencil rules in plain integer arithmetic.
  function automatic int ref_val(input int n, input int s, input int e, input int w,
                                 input int c, input bit fx, input int md);
    int sum;
    sum = n + s + e + w;
    if (fx) return c;
    case (md)
      0:       return sum / 4;
      1:       return (sum + 2) / 4;
      2:       return (c + sum / 4) / 2;
      default: return c;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) out_ready = ($urandom_range(0, 1) == 1);
    else if (bp_k >= 0) begin
      bp_k++;
      out_ready = !(bp_k >= 2 && bp_k <= 6);
    end
  endtask

  task automatic send_cell(input int n, input int s, input int e, input int w,
                           input int c, input bit fx, input int md, input bit lat);
    bit   ok;
    exp_t x;
    int   v;
    in_n = WIDTH'(n); in_s = WIDTH'(s); in_e = WIDTH'(e); in_w = WIDTH'(w);
    in_c = WIDTH'(c); in_fixed = fx; in_mode = 2'(md);
    in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      saw_stall = 1'b1;
      tick();
    end
    if (ok) begin
      v = ref_val(n, s, e, w, c, fx, md);
      x.val = v;
      x.dlt = (v > c) ? v - c : c - v;
      x.acc = cyc;
      x.lat = lat;
      q.push_back(x);
    end else begin
      chk("accept_timeout", 0, 1);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 300; k++) begin
      if (q.size() == 0) break;
      tick();
    end
    tick();
    tick();
    chk("drain_left", q.size(), 0);
  endtask

  task automatic clear_pulse();
    sweep_clear = 1'b1;
    tick();
    sweep_clear = 1'b0;
  endtask

  // Monitor: compare registered state against the model, then fold in this cycle's handshake.
  initial begin
    exp_t e;
    int   m;
    bit   hs;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("in_ready", int'(in_ready), int'(!out_valid || out_ready));
        chk("cell_idx", int'(cell_idx), sw_q.size());
        chk("sweep_done", int'(sweep_done), int'(exp_done));
        chk("max_delta", int'(max_delta), exp_max);
        chk("converged", int'(converged), int'(exp_conv));
        exp_done = 1'b0;
        hs = out_valid && out_ready;
        if (hs) begin
          if (q.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            e = q.pop_front();
            chk("out_val", int'(out_val), e.val);
            chk("out_delta", int'(out_delta), e.dlt);
            if (e.lat) chk("latency", cyc - e.acc, 2);
            if (!sweep_clear) begin
              sw_q.push_back(e.dlt);
              if (sw_q.size() == CELLS) begin
                m = 0;
                foreach (sw_q[i]) if (sw_q[i] > m) m = sw_q[i];
                exp_max  = m;
                exp_conv = (m <= int'(threshold));
                exp_done = 1'b1;
                sw_q.delete();
              end
            end
          end
        end
        if (sweep_clear) sw_q.delete();
      end
    end
  end

  initial begin
    int d1[4];
    int d2[4];
    n_checks = 0; n_pass = 0;
    exp_max = 0; exp_conv = 1'b0; exp_done = 1'b0;
    rnd_rdy = 1'b0; bp_k = -1; saw_stall = 1'b0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sweep_clear = 1'b0;
    in_n = '0; in_s = '0; in_e = '0; in_w = '0; in_c = '0; in_fixed = 1'b0; in_mode = 2'd0;
    threshold = 8'd5;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_val", int'(out_val), 0);
    chk("rst_max_delta", int'(max_delta), 0);
    tick();

    // Modes and extremes, back-to-back with latency checks
    send_cell(10, 20, 30, 42, 0, 1'b0, 0, 1'b1);
    send_cell(10, 20, 30, 42, 0, 1'b0, 1, 1'b1);
    send_cell(10, 20, 30, 42, 0, 1'b0, 2, 1'b1);
    send_cell(10, 20, 30, 42, 0, 1'b0, 3, 1'b1);
    send_cell(255, 255, 255, 255, 0, 1'b0, 1, 1'b1);
    send_cell(100, 100, 100, 100, 0, 1'b0, 2, 1'b1);
    send_cell(0, 0, 0, 0, 255, 1'b0, 2, 1'b1);
    send_cell(200, 200, 200, 200, 77, 1'b1, 0, 1'b1);
    drain();

    // Backpressure: out_ready low for cycles 2..6 of the stream
    saw_stall = 1'b0;
    bp_k = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_cell(11 * i, 13 * i, 7, 40 + i, 3 * i, 1'b0, i % 3, 1'b0);
    chk("bp_in_ready_dropped", int'(saw_stall), 1);
    bp_k = -1;
    out_ready = 1'b1;
    drain();

    // Two full sweeps with threshold 5
    d1 = '{3, 7, 1, 2};
    d2 = '{5, 0, 4, 1};
    threshold = 8'd5;
    clear_pulse();
    foreach (d1[i]) send_cell(100, 100, 100, 100, 100 - d1[i], 1'b0, 0, 1'b1);
    drain();
    chk("sweep1_max", int'(max_delta), 7);
    chk("sweep1_conv", int'(converged), 0);
    chk("sweep1_idx", int'(cell_idx), 0);
    foreach (d2[i]) send_cell(100, 100, 100, 100, 100 - d2[i], 1'b0, 0, 1'b1);
    drain();
    chk("sweep2_max", int'(max_delta), 5);
    chk("sweep2_conv", int'(converged), 1);

    // Clear coincident with the last handshake of a sweep
    clear_pulse();
    for (int i = 0; i < 3; i++) send_cell(100, 100, 100, 100, 91, 1'b0, 0, 1'b0);
    drain();
    out_ready = 1'b0;
    send_cell(100, 100, 100, 100, 91, 1'b0, 0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) break;
      tick();
    end
    tick();
    out_ready = 1'b1;
    sweep_clear = 1'b1;
    tick();
    sweep_clear = 1'b0;
    @(negedge clk);
    chk("clr_no_done", int'(sweep_done), 0);
    chk("clr_max_kept", int'(max_delta), 5);
    chk("clr_conv_kept", int'(converged), 1);
    chk("clr_idx", int'(cell_idx), 0);
    tick();
    drain();

    // Randomised traffic with random backpressure, thresholds and occasional clears
    rnd_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      threshold = 8'($urandom_range(0, 255));
      sweep_clear = ($urandom_range(0, 15) == 0);
      send_cell($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(0, 255),
                ($urandom_range(0, 7) == 0), $urandom_range(0, 3), 1'b0);
      sweep_clear = 1'b0;
      if ($urandom_range(0, 3) == 0) tick();
    end
    rnd_rdy = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset mid-stall with two cells in flight
    send_cell(9, 9, 9, 9, 200, 1'b0, 0, 1'b0);
    out_ready = 1'b0;
    send_cell(50, 60, 70, 80, 1, 1'b0, 1, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_val", int'(out_val), 0);
    chk("arst_out_delta", int'(out_delta), 0);
    chk("arst_cell_idx", int'(cell_idx), 0);
    chk("arst_max_delta", int'(max_delta), 0);
    chk("arst_converged", int'(converged), 0);
    chk("arst_sweep_done", int'(sweep_done), 0);
    q.delete();
    sw_q.delete();
    exp_max = 0; exp_conv = 1'b0; exp_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", int'(in_ready), 1);
    repeat (10) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stencil_cell_engine.md
# stencil_cell_engine

Pipelined, parametrised successor to the single-cell neighbour-average ALU. It accepts one grid cell per handshake, carrying its four neighbours and its old centre value. It computes the updated value in one of four selectable stencil modes and reports the per-cell change. Across each sweep of `CELLS` cells it tracks the maximum change and raises a convergence flag, so the grid sequencer can decide when to stop iterating.

## Interface
Parameters:
- `WIDTH`, 8, bit width of every cell value.
- `CELLS`, 16, cells per sweep; must be ≥ 2.
- `CNT_W`, `$clog2(CELLS)`, width of the cell counter (derived, not overridden).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input cell present.
- `in_ready`  out  1  engine accepts input this cycle.
- `in_n`, `in_s`, `in_e`, `in_w`  in  WIDTH each  neighbour values, unsigned.
- `in_c`  in  WIDTH  old centre value.
- `in_fixed`  in  1  boundary cell; output is pinned to `in_c`.
- `in_mode`  in  2  stencil mode, sampled with each accepted cell.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  downstream accepts result.
- `out_val`  out  WIDTH  new cell value.
- `out_delta`  out  WIDTH  |out_val − old centre|.
- `threshold`  in  WIDTH  convergence limit, sampled at sweep end.
- `sweep_clear`  in  1  synchronous restart of sweep tracking.
- `cell_idx`  out  CNT_W  index of the next cell to complete in the sweep.
- `max_delta`  out  WIDTH  maximum delta of the last completed sweep.
- `converged`  out  1  last completed sweep had `max_delta` ≤ `threshold`.
- `sweep_done`  out  1  one-cycle pulse when a sweep completes.

## Operation
- Two-stage pipeline under a global enable `en = !out_valid || out_ready`.
  - `in_ready = en`.
  - An input handshake is `in_valid && in_ready`; an output handshake is `out_valid && out_ready`.
- Stage 1 registers:
  - S = n+s+e+w at WIDTH+2 bits (cannot overflow);
  - `in_c`, `in_fixed`, `in_mode`, and a valid bit (loaded with `in_valid` when `en`).
- Stage 2 computes the new value into the output registers. With A = S>>2, by mode:
  - 0, truncating average: A.
  - 1, rounded average: (S+2)>>2. Maximum is 2^WIDTH−1, so no saturation is needed.
  - 2, damped relaxation: (c + A)>>1, summed at WIDTH+1 bits.
  - 3, hold: c.
- `in_fixed` = 1 overrides every mode: new value = c.
- `out_delta` = |new − c|, computed at WIDTH+1 bits and truncated to WIDTH.
- Sweep tracking advances only on an output handshake:
  - `cell_idx` increments. An internal running max takes max(running, `out_delta`).
  - On the handshake at `cell_idx` = CELLS−1: `cell_idx` wraps to 0, `max_delta` ← max(running, `out_delta`), `converged` ← (that value ≤ `threshold`), the running max clears to 0, and `sweep_done` pulses.
- `sweep_clear` clears `cell_idx` and the running max. `max_delta` and `converged` keep their values.
  - `sweep_clear` wins over a coincident last-cell handshake: no `sweep_done` and no update of `max_delta`/`converged`.
  - `sweep_clear` does not flush pipeline data.

## Timing
- Latency: an accepted cell appears on `out_*` 2 cycles after acceptance when unstalled. Throughput is 1 cell/cycle.
- Stall: while `out_valid && !out_ready`, `in_ready` is 0 and both stages hold. No data is lost or duplicated, and order is preserved.
- Bubbles: an empty stage still advances when `en` is 1. The pipeline is not compressed while stalled.
- `sweep_done` is registered: high for exactly the cycle after the final handshake of a sweep. `max_delta` and `converged` become valid in that same cycle.
- Reset (asynchronous, any time, including mid-sweep or mid-stall): all stage valids, `out_valid`, `out_val`, `out_delta`, `cell_idx`, running max, `max_delta`, `converged`, and `sweep_done` go to 0. In-flight cells are discarded. `in_ready` is 1 from the first cycle after reset deasserts.
- `in_*` values and `in_mode` are not required to be stable when `in_ready` = 0.

## Test plan
- Modes, WIDTH=8, c=0, n,s,e,w = 10,20,30,42 (S=102):
  - mode 0 → out_val 25, delta 25;
  - mode 1 → 26;
  - mode 3 → 0, delta 0;
  - each result appears 2 cycles after acceptance.
- Extremes:
  - all neighbours 255, mode 1 → 255;
  - mode 2, c=0, neighbours 100 → 50, delta 50;
  - mode 2, c=255, neighbours 0 → 127, delta 128.
- `in_fixed`=1, mode 0, c=77, neighbours 200 → out_val 77, delta 0.
- Backpressure: stream 4 cells back-to-back with `out_ready`=0 for cycles 2–6:
  - `in_ready` drops once `out_valid` is held;
  - all 4 results emerge in order with correct values;
  - no duplicates.
- Sweep, CELLS=4, threshold 5:
  - deltas 3,7,1,2 → one `sweep_done` pulse, max_delta 7, converged 0, cell_idx 0;
  - next sweep deltas 5,0,4,1 → max_delta 5, converged 1.
- Boundaries:
  - `sweep_clear` coincident with the 4th handshake → no `sweep_done`, max_delta unchanged, cell_idx 0;
  - `rst` asserted mid-stall with 2 cells in flight → all outputs 0 immediately, no results emerge afterwards.
